// File: rtl/synthesijer_op_issue32_pkg.sv
// Shared definitions for the operator issue/capture stage.
// Contents: FSM state encoding, datapath width, default counter width.
// Imported by synthesijer_op_issue32.
package synthesijer_op_issue32_pkg;

  localparam int DATA_W        = 32;
  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/synthesijer_op_issue32.sv
// Single-slot issue/capture stage in front of a 32-bit two-operand operator.
// Latency: response 2+MIN_LATENCY cycles after accept (operator valid permitting);
//   a stalled operator yields an error response after TIMEOUT WAIT cycles.
// Backpressure: one op in flight; the response is held until resp_ready, and
//   req_ready follows resp_ready in HOLD so the slot can be refilled on the same edge.
// Ports: clk/reset (async, active-high); req_* operand handshake in;
//   op_a/op_b/op_nd to operator, op_result/op_valid from operator;
//   resp_data/resp_err/resp_valid/resp_ready response handshake out.
module synthesijer_op_issue32
  import synthesijer_op_issue32_pkg::*;
#(
  parameter int MIN_LATENCY = 0,
  parameter int TIMEOUT     = 0,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              req_valid,
  output logic              req_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              op_nd,
  input  logic [DATA_W-1:0] op_result,
  input  logic              op_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              resp_valid,
  input  logic              resp_ready
);

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MIN_LATENCY);
  // Value of to_cnt on the last permitted WAIT cycle; only meaningful when TO_EN.
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam bit               TO_EN    = (TIMEOUT != 0);

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  op_a_q, op_a_d;
  logic [DATA_W-1:0]  op_b_q, op_b_d;
  logic               op_nd_q, op_nd_d;
  logic [DATA_W-1:0]  resp_data_q, resp_data_d;
  logic               resp_err_q, resp_err_d;
  logic               resp_valid_q, resp_valid_d;
  logic [CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0]   to_cnt_q, to_cnt_d;
  logic               capture;

  // Ready in HOLD depends on the consumer so a new op can enter as the old
  // response leaves.
  assign req_ready = (state_q == IDLE) || ((state_q == HOLD) && resp_ready);

  // op_valid only counts once the minimum latency has elapsed.
  assign capture = (state_q == WAIT) && (lat_cnt_q == '0) && op_valid;

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_nd_d      = 1'b0;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    resp_valid_d = resp_valid_q;
    lat_cnt_d    = lat_cnt_q;
    to_cnt_d     = to_cnt_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_a_d  = req_a;
          op_b_d  = req_b;
          op_nd_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        lat_cnt_d = LAT_INIT;
        to_cnt_d  = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        to_cnt_d = to_cnt_q + CNT_W'(1);
        if (lat_cnt_q != '0) begin
          lat_cnt_d = lat_cnt_q - CNT_W'(1);
        end
        // Capture is tested first so it wins over a coincident timeout.
        if (capture) begin
          resp_data_d  = op_result;
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = HOLD;
        end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
          resp_data_d  = '0;
          resp_err_d   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          if (req_valid) begin
            op_a_d  = req_a;
            op_b_d  = req_b;
            op_nd_d = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_nd_q      <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      lat_cnt_q    <= '0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_nd_q      <= op_nd_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      resp_valid_q <= resp_valid_d;
      lat_cnt_q    <= lat_cnt_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign op_nd      = op_nd_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign resp_valid = resp_valid_q;

endmodule
